// File: rtl/xif_result_queue.sv
// In-order result FIFO between the FPU's CORE-V-XIF result channel and the core.
// Optional define XIF_RESULT_BYPASS_EN adds a zero-latency in_* -> out_* path when empty.
module xif_result_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned FLEN       = 32
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [X_ID_WIDTH-1:0]   in_id,
  input  logic [FLEN-1:0]         in_data,
  input  logic [4:0]              in_rd,
  input  logic                    in_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [X_ID_WIDTH-1:0]   out_id,
  output logic [FLEN-1:0]         out_data,
  output logic [4:0]              out_rd,
  output logic                    out_we,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [FLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem[rd_ptr_q[AW-1:0]];

  assign in_ready = !full;
  assign pop      = !empty && out_ready;
`ifdef XIF_RESULT_BYPASS_EN
  // A result consumed on the bypass path in the same cycle is never stored.
  assign push = in_valid && in_ready && !(empty && out_ready);
`else
  assign push = in_valid && in_ready;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_id    = '0;
    out_data  = '0;
    out_rd    = '0;
    out_we    = 1'b0;
    if (!empty) begin
      out_valid = 1'b1;
      out_id    = head.id;
      out_data  = head.data;
      out_rd    = head.rd;
      out_we    = head.we;
    end
`ifdef XIF_RESULT_BYPASS_EN
    else if (in_valid) begin
      out_valid = 1'b1;
      out_id    = in_id;
      out_data  = in_data;
      out_rd    = in_rd;
      out_we    = in_we;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left uninitialised; occupancy alone decides validity.
  always_ff @(posedge ck) begin
    if (push && !flush) begin
      mem[wr_ptr_q[AW-1:0]] <= '{id: in_id, data: in_data, rd: in_rd, we: in_we};
    end
  end

endmodule
